// File: rtl/banked_regfile_mp_if.sv
// Register-file bus: operand-fetch read ports, writeback write ports,
// PC control and error reporting. The core drives it as master, the
// register file sits on the slave side.
interface banked_regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int NUM_RD = 3,
    parameter int NUM_WR = 2
);
    logic [4:0]             M;
    logic [4*NUM_RD-1:0]    rd_addr;
    logic [DATA_W*NUM_RD-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_err;
    logic [NUM_WR-1:0]      we;
    logic [4*NUM_WR-1:0]    wr_addr;
    logic [DATA_W*NUM_WR-1:0] wr_data;
    logic                   pc_we;
    logic [DATA_W-1:0]      pc_data;
    logic                   pc_inc;
    logic [DATA_W-1:0]      pc_out;
    logic                   wr_err;
    logic                   err_sticky;
    logic                   err_clr;

    modport master (
        output M, rd_addr, we, wr_addr, wr_data, pc_we, pc_data, pc_inc, err_clr,
        input  rd_data, rd_err, pc_out, wr_err, err_sticky
    );

    modport slave (
        input  M, rd_addr, we, wr_addr, wr_data, pc_we, pc_data, pc_inc, err_clr,
        output rd_data, rd_err, pc_out, wr_err, err_sticky
    );
endinterface

// File: rtl/banked_regfile_mp.sv
// ARM-style banked register file. The {mode, arch reg} pair is folded onto
// a flat array of 33 physical entries; r15 is a separate PC register.
// Reads are combinational with optional same-cycle write bypass; illegal or
// conflicting writes raise a one-cycle wr_err and the sticky error flag.
module banked_regfile_mp #(
    parameter int                DATA_W      = 32,
    parameter int                NUM_RD      = 3,
    parameter int                NUM_WR      = 2,
    parameter bit                FWD_EN      = 1'b1,
    parameter logic [DATA_W-1:0] RESET_PC    = '0,
    parameter logic [DATA_W-1:0] PC_INC      = DATA_W'(4),
    parameter logic [DATA_W-1:0] PC_READ_OFS = '0
) (
    input  logic               clk,
    input  logic               rst,
    banked_regfile_mp_if.slave bus
);
    localparam int NUM_PHYS = 33;

    localparam logic [4:0] M_USR = 5'b10000;
    localparam logic [4:0] M_FIQ = 5'b10001;
    localparam logic [4:0] M_IRQ = 5'b10010;
    localparam logic [4:0] M_SVC = 5'b10011;
    localparam logic [4:0] M_MON = 5'b10110;
    localparam logic [4:0] M_ABT = 5'b10111;
    localparam logic [4:0] M_HYP = 5'b11010;
    localparam logic [4:0] M_UND = 5'b11011;
    localparam logic [4:0] M_SYS = 5'b11111;

    typedef struct packed {
        logic       ok;
        logic [5:0] idx;
    } map_t;

    function automatic logic mode_valid(input logic [4:0] m);
        case (m)
            M_USR, M_FIQ, M_IRQ, M_SVC, M_MON,
            M_ABT, M_HYP, M_UND, M_SYS: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    // r15 has no physical entry, so it always maps as not-ok here; reads of
    // r15 are served from the PC register before this mapping is consulted.
    function automatic map_t map_reg(input logic [4:0] m, input logic [3:0] a);
        map_t       r;
        logic [5:0] base;
        r.ok  = mode_valid(m);
        r.idx = {2'b00, a};
        case (m)
            M_USR, M_SYS: base = 6'd13;
            M_FIQ:        base = 6'd20;
            M_IRQ:        base = 6'd22;
            M_SVC:        base = 6'd24;
            M_MON:        base = 6'd26;
            M_ABT:        base = 6'd28;
            M_HYP:        base = 6'd30;
            M_UND:        base = 6'd31;
            default:      base = 6'd13;
        endcase
        if (a == 4'd15) begin
            r.ok = 1'b0;
        end else if (a >= 4'd13) begin
            r.idx = base + {5'd0, (a == 4'd14)};
            if (m == M_HYP && a == 4'd14) r.ok = 1'b0;
        end else if (a >= 4'd8 && m == M_FIQ) begin
            r.idx = {2'b00, a} + 6'd7;
        end
        return r;
    endfunction

    logic [DATA_W-1:0]        phys [NUM_PHYS];
    logic [DATA_W-1:0]        pc_q;
    logic                     wr_err_q;
    logic                     sticky_q;

    logic [NUM_WR-1:0]        wr_ok;
    logic [5:0]               wr_idx [NUM_WR];
    logic                     wr_err_c;
    logic [DATA_W*NUM_RD-1:0] rd_data_c;
    logic [NUM_RD-1:0]        rd_err_c;

    // Decode write ports: legality, target entry, and same-entry conflicts.
    always_comb begin
        map_t wm;
        wr_ok    = '0;
        wr_err_c = 1'b0;
        wm       = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            wm        = map_reg(bus.M, bus.wr_addr[4*j +: 4]);
            wr_idx[j] = wm.idx;
            wr_ok[j]  = bus.we[j] & wm.ok;
            if (bus.we[j] && !wm.ok) wr_err_c = 1'b1;
        end
        for (int j = 1; j < NUM_WR; j++) begin
            for (int i = 0; i < j; i++) begin
                if (wr_ok[i] && wr_ok[j] && wr_idx[i] == wr_idx[j]) wr_err_c = 1'b1;
            end
        end
    end

    // Read ports: PC for r15, banked entry otherwise, with optional bypass
    // where a later (higher-index) write port overrides an earlier one.
    always_comb begin
        logic [3:0]        a;
        map_t              rm;
        logic [DATA_W-1:0] v;
        rd_data_c = '0;
        rd_err_c  = '0;
        a         = '0;
        rm        = '0;
        v         = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            a = bus.rd_addr[4*k +: 4];
            if (!mode_valid(bus.M)) begin
                rd_err_c[k] = 1'b1;
            end else if (a == 4'd15) begin
                rd_data_c[DATA_W*k +: DATA_W] = pc_q + PC_READ_OFS;
            end else begin
                rm = map_reg(bus.M, a);
                if (!rm.ok) begin
                    rd_err_c[k] = 1'b1;
                end else begin
                    v = phys[rm.idx];
                    if (FWD_EN) begin
                        for (int j = 0; j < NUM_WR; j++) begin
                            if (wr_ok[j] && wr_idx[j] == rm.idx)
                                v = bus.wr_data[DATA_W*j +: DATA_W];
                        end
                    end
                    rd_data_c[DATA_W*k +: DATA_W] = v;
                end
            end
        end
    end

    // Physical storage; ascending port order makes the highest port win.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PHYS; i++) phys[i] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_ok[j]) phys[wr_idx[j]] <= bus.wr_data[DATA_W*j +: DATA_W];
            end
        end
    end

    // PC register, error pulse and sticky error (set beats clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            wr_err_q <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            if (bus.pc_we)       pc_q <= bus.pc_data;
            else if (bus.pc_inc) pc_q <= pc_q + PC_INC;
            wr_err_q <= wr_err_c;
            if (|rd_err_c || wr_err_c) sticky_q <= 1'b1;
            else if (bus.err_clr)      sticky_q <= 1'b0;
        end
    end

    assign bus.rd_data    = rd_data_c;
    assign bus.rd_err     = rd_err_c;
    assign bus.pc_out     = pc_q;
    assign bus.wr_err     = wr_err_q;
    assign bus.err_sticky = sticky_q;
endmodule

// File: tb/tb_banked_regfile_mp.sv
// Bench for banked_regfile_mp: directed scenarios followed by randomized
// traffic, compared against a model that names each architectural bank
// ("r5", "fiq_r9", "irq_r13", ...) and stores them in an associative array.
module tb_banked_regfile_mp;
    localparam int          DATA_W  = 32;
    localparam int          NUM_RD  = 3;
    localparam int          NUM_WR  = 2;
    localparam logic [31:0] RST_PC  = 32'h0000_0040;
    localparam logic [31:0] RD_OFS  = 32'd8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    banked_regfile_mp_if #(.DATA_W(DATA_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus ();

    banked_regfile_mp #(
        .DATA_W(DATA_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .FWD_EN(1'b1),
        .RESET_PC(RST_PC), .PC_INC(32'd4), .PC_READ_OFS(RD_OFS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Reference state
    logic [31:0] regs [string];
    logic [31:0] m_pc;
    logic        m_werr;
    logic        m_sticky;

    function automatic bit mode_ok(input logic [4:0] m);
        return m inside {5'h10, 5'h11, 5'h12, 5'h13, 5'h16, 5'h17, 5'h1A, 5'h1B, 5'h1F};
    endfunction

    function automatic string bank_name(input logic [4:0] m);
        case (m)
            5'h10, 5'h1F: return "usr";
            5'h11:        return "fiq";
            5'h12:        return "irq";
            5'h13:        return "svc";
            5'h16:        return "mon";
            5'h17:        return "abt";
            5'h1A:        return "hyp";
            5'h1B:        return "und";
            default:      return "";
        endcase
    endfunction

    // Name of the storage an access reaches; "" means no legal storage.
    function automatic string key(input logic [4:0] m, input logic [3:0] a);
        if (!mode_ok(m) || a == 4'd15) return "";
        if (a < 4'd8) return $sformatf("r%0d", a);
        if (a <= 4'd12) return (m == 5'h11) ? $sformatf("fiq_r%0d", a) : $sformatf("r%0d", a);
        if (m == 5'h1A && a == 4'd14) return "";
        return $sformatf("%s_r%0d", bank_name(m), a);
    endfunction

    function automatic void exp_read(input int k, output logic [31:0] d, output logic e);
        logic [3:0] a;
        string      s;
        a = bus.rd_addr[4*k +: 4];
        d = '0;
        e = 1'b0;
        if (!mode_ok(bus.M)) begin
            e = 1'b1;
        end else if (a == 4'd15) begin
            d = m_pc + RD_OFS;
        end else begin
            s = key(bus.M, a);
            if (s == "") begin
                e = 1'b1;
            end else begin
                d = regs.exists(s) ? regs[s] : 32'd0;
                for (int j = 0; j < NUM_WR; j++)
                    if (bus.we[j] && key(bus.M, bus.wr_addr[4*j +: 4]) == s)
                        d = bus.wr_data[32*j +: 32];
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] d;
        logic        e;
        for (int k = 0; k < NUM_RD; k++) begin
            exp_read(k, d, e);
            chk($sformatf("%s rd_data[%0d]", tag, k), 64'(bus.rd_data[32*k +: 32]), 64'(d));
            chk($sformatf("%s rd_err[%0d]", tag, k), 64'(bus.rd_err[k]), 64'(e));
        end
        chk({tag, " pc_out"}, 64'(bus.pc_out), 64'(m_pc));
        chk({tag, " wr_err"}, 64'(bus.wr_err), 64'(m_werr));
        chk({tag, " err_sticky"}, 64'(bus.err_sticky), 64'(m_sticky));
    endtask

    // Advance one clock, updating the model from the inputs held before the edge.
    task automatic clk_step();
        logic        werr;
        logic        rerr;
        logic [31:0] d;
        logic        e;
        logic [31:0] wd [NUM_WR];
        string       ks [NUM_WR];
        logic        pwe, pinc, clr;
        logic [31:0] pdat;
        werr = 1'b0;
        rerr = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            exp_read(k, d, e);
            rerr |= e;
        end
        for (int j = 0; j < NUM_WR; j++) begin
            ks[j] = bus.we[j] ? key(bus.M, bus.wr_addr[4*j +: 4]) : "";
            wd[j] = bus.wr_data[32*j +: 32];
            if (bus.we[j] && ks[j] == "") werr = 1'b1;
        end
        for (int j = 1; j < NUM_WR; j++)
            for (int i = 0; i < j; i++)
                if (ks[i] != "" && ks[i] == ks[j]) werr = 1'b1;
        pwe  = bus.pc_we;
        pinc = bus.pc_inc;
        pdat = bus.pc_data;
        clr  = bus.err_clr;
        @(posedge clk);
        for (int j = 0; j < NUM_WR; j++)
            if (ks[j] != "") regs[ks[j]] = wd[j];
        if (pwe)       m_pc = pdat;
        else if (pinc) m_pc = m_pc + 32'd4;
        m_werr = werr;
        if (rerr || werr) m_sticky = 1'b1;
        else if (clr)     m_sticky = 1'b0;
        #1;
    endtask

    task automatic model_reset();
        regs.delete();
        m_pc     = RST_PC;
        m_werr   = 1'b0;
        m_sticky = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.we      = '0;
        bus.pc_we   = 1'b0;
        bus.pc_inc  = 1'b0;
        bus.err_clr = 1'b0;
        bus.rd_addr = '0;
    endtask

    logic [4:0] modes [9] = '{5'h10, 5'h11, 5'h12, 5'h13, 5'h16, 5'h17, 5'h1A, 5'h1B, 5'h1F};

    initial begin
        rst         = 1'b1;
        bus.M       = 5'h10;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.pc_data = '0;
        idle_inputs();
        model_reset();
        #12;
        chk("reset pc_out", 64'(bus.pc_out), 64'(RST_PC));
        chk("reset wr_err", 64'(bus.wr_err), 64'd0);
        chk("reset err_sticky", 64'(bus.err_sticky), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all("post-reset");

        // Plain write then read on every port
        bus.M = 5'h10; bus.we = 2'b01; bus.wr_addr = {4'd0, 4'd5};
        bus.wr_data = {32'd0, 32'hA5A5_0001};
        clk_step();
        bus.we = '0; bus.rd_addr = {4'd5, 4'd5, 4'd5};
        #1;
        check_all("t1");
        chk("t1 r5 value", 64'(bus.rd_data[95:64]), 64'h A5A5_0001);

        // Banked r13 across modes
        bus.we = 2'b01; bus.wr_addr = {4'd0, 4'd13}; bus.wr_data = {32'd0, 32'h100};
        clk_step();
        bus.M = 5'h11; bus.wr_data = {32'd0, 32'h200};
        clk_step();
        bus.we = '0; bus.M = 5'h12; bus.rd_addr = {4'd13, 4'd13, 4'd13};
        #1;
        check_all("t2 irq");
        chk("t2 irq r13", 64'(bus.rd_data[31:0]), 64'd0);
        bus.M = 5'h11; #1;
        chk("t2 fiq r13", 64'(bus.rd_data[31:0]), 64'h200);
        bus.M = 5'h1F; #1;
        check_all("t2 sys");
        chk("t2 sys r13", 64'(bus.rd_data[31:0]), 64'h100);

        // Hyp r14 has no bank
        bus.M = 5'h1A; bus.rd_addr = '0; bus.we = 2'b01;
        bus.wr_addr = {4'd0, 4'd14}; bus.wr_data = {32'd0, 32'hDEAD_BEEF};
        #1;
        check_all("t3 pre");
        clk_step();
        bus.we = '0;
        #1;
        check_all("t3 post");
        chk("t3 wr_err", 64'(bus.wr_err), 64'd1);
        chk("t3 sticky", 64'(bus.err_sticky), 64'd1);
        bus.rd_addr = {4'd13, 4'd0, 4'd14};
        #1;
        check_all("t3 read r14");
        chk("t3 rd_err", 64'(bus.rd_err), 64'b001);
        clk_step();
        chk("t3 wr_err drop", 64'(bus.wr_err), 64'd0);
        bus.rd_addr = '0; bus.err_clr = 1'b1;
        clk_step();
        bus.err_clr = 1'b0;
        #1;
        check_all("t3 clr");
        chk("t3 sticky cleared", 64'(bus.err_sticky), 64'd0);

        // Two ports hit r3
        bus.M = 5'h10; bus.we = 2'b11; bus.wr_addr = {4'd3, 4'd3};
        bus.wr_data = {32'h22, 32'h11}; bus.rd_addr = {4'd3, 4'd3, 4'd3};
        #1;
        check_all("t4 bypass");
        chk("t4 bypass r3", 64'(bus.rd_data[31:0]), 64'h22);
        clk_step();
        bus.we = '0;
        #1;
        check_all("t4 after");
        chk("t4 r3", 64'(bus.rd_data[63:32]), 64'h22);
        chk("t4 wr_err", 64'(bus.wr_err), 64'd1);
        bus.err_clr = 1'b1;
        clk_step();
        bus.err_clr = 1'b0;

        // PC wrap and load priority
        bus.pc_we = 1'b1; bus.pc_data = 32'hFFFF_FFFC;
        clk_step();
        bus.pc_we = 1'b0; bus.pc_inc = 1'b1;
        chk("t5 pc load", 64'(bus.pc_out), 64'hFFFF_FFFC);
        clk_step();
        bus.pc_inc = 1'b0; bus.rd_addr = {4'd15, 4'd15, 4'd15};
        #1;
        check_all("t5 wrap");
        chk("t5 pc wrap", 64'(bus.pc_out), 64'd0);
        chk("t5 r15 read", 64'(bus.rd_data[31:0]), 64'(RD_OFS));
        bus.pc_we = 1'b1; bus.pc_inc = 1'b1; bus.pc_data = 32'h1234;
        clk_step();
        chk("t5 pc_we wins", 64'(bus.pc_out), 64'h1234);
        idle_inputs();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            bus.M = ($urandom_range(0, 9) == 0) ? 5'($urandom) : modes[$urandom_range(0, 8)];
            bus.rd_addr = 12'($urandom);
            bus.we      = 2'($urandom);
            bus.wr_addr = 8'($urandom);
            if ($urandom_range(0, 3) == 0) bus.wr_addr[7:4] = bus.wr_addr[3:0];
            bus.wr_data = {32'($urandom), 32'($urandom)};
            bus.pc_we   = ($urandom_range(0, 7) == 0);
            bus.pc_inc  = $urandom_range(0, 1) == 1;
            bus.pc_data = 32'($urandom);
            bus.err_clr = $urandom_range(0, 1) == 1;
            #1;
            check_all($sformatf("rand%0d", n));
            clk_step();
        end
        idle_inputs();

        // Asynchronous reset mid-write
        bus.M = 5'h11; bus.we = 2'b11; bus.wr_addr = {4'd15, 4'd9};
        bus.wr_data = {32'd0, 32'h99};
        clk_step();
        bus.we = 2'b01; bus.wr_data = {32'd0, 32'h77};
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("t6 pc_out in reset", 64'(bus.pc_out), 64'(RST_PC));
        chk("t6 wr_err in reset", 64'(bus.wr_err), 64'd0);
        chk("t6 sticky in reset", 64'(bus.err_sticky), 64'd0);
        @(posedge clk);
        #1;
        bus.we = '0;
        @(negedge clk);
        rst = 1'b0;
        bus.rd_addr = {4'd9, 4'd9, 4'd9};
        #1;
        check_all("t6 after");
        chk("t6 fiq r9", 64'(bus.rd_data[31:0]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
